// File: rtl/router_pkg.sv
// Shared router types: flit type codes, header field layout, injector FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_pkg;

    // Two-bit flit type carried in the top bits of every flit.
    typedef enum logic [1:0] {
        FT_BODY     = 2'b00,
        FT_TAIL     = 2'b01,
        FT_HEAD     = 2'b10,
        FT_HEADTAIL = 2'b11
    } flit_type_t;

    localparam int FLIT_TYPE_W  = 2;

    // Header payload field layout (bit offsets into the flit).
    localparam int HDR_COORD_W  = 4;
    localparam int HDR_DSTX_LSB = 0;
    localparam int HDR_DSTY_LSB = 4;
    localparam int HDR_SRCX_LSB = 8;
    localparam int HDR_SRCY_LSB = 12;
    localparam int HDR_LEN_LSB  = 16;
    localparam int HDR_LEN_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } injector_state_t;

endpackage

// File: rtl/proc_injector.sv
// Processor-side wormhole packet injector: command + payload stream -> framed flits.
// Latency: header valid one cycle after command accept; body flits pass through combinationally.
// Backpressure: header held stable until ready; body follows pay_valid, pay_ready mirrors ready.
//
// Ports: clk/rst (sync, active-high); cmd_* send command (valid/ready, dst x/y, length);
// pay_* payload words (valid/ready/data); proc_output_* flit channel to router proc_input;
// pkt_sent / cmd_err one-cycle registered pulses; pkt_count wrapping completed-packet count.
module proc_injector
    import router_pkg::*;
#(
    parameter int n    = 32,
    parameter int srcx = 0,
    parameter int srcy = 0,
    parameter int maxx = 1,
    parameter int maxy = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_dstx,
    input  logic [3:0]   cmd_dsty,
    input  logic [7:0]   cmd_len,
    input  logic         pay_valid,
    output logic         pay_ready,
    input  logic [n-3:0] pay_data,
    output logic         proc_output_valid,
    input  logic         proc_output_ready,
    output logic [n-1:0] proc_output_data,
    output logic         pkt_sent,
    output logic         cmd_err,
    output logic [15:0]  pkt_count
);

    localparam logic [3:0] SRC_X = 4'(srcx);
    localparam logic [3:0] SRC_Y = 4'(srcy);
    localparam logic [3:0] MAX_X = 4'(maxx);
    localparam logic [3:0] MAX_Y = 4'(maxy);

    injector_state_t state_q, state_d;
    logic [3:0]      dstx_q, dsty_q;
    logic [7:0]      len_q;
    logic [7:0]      remaining_q;
    logic            cmd_fire, cmd_legal, out_fire, last_flit;
    logic [n-1:0]    hdr;
    flit_type_t      hdr_type, body_type;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_legal = !((cmd_dstx > MAX_X) || (cmd_dsty > MAX_Y) ||
                         ((cmd_dstx == SRC_X) && (cmd_dsty == SRC_Y)));
    assign out_fire  = proc_output_valid && proc_output_ready;
    // The flit on the channel closes the worm: a zero-length header or the final body word.
    assign last_flit = ((state_q == ST_HEAD) && (len_q == 8'd0)) ||
                       ((state_q == ST_BODY) && (remaining_q == 8'd1));

    assign hdr_type  = (len_q == 8'd0) ? FT_HEADTAIL : FT_HEAD;
    assign body_type = (remaining_q == 8'd1) ? FT_TAIL : FT_BODY;

    // Header is built only from latched fields, so it cannot change while stalled.
    always_comb begin
        hdr = '0;
        hdr[HDR_DSTX_LSB +: HDR_COORD_W]  = dstx_q;
        hdr[HDR_DSTY_LSB +: HDR_COORD_W]  = dsty_q;
        hdr[HDR_SRCX_LSB +: HDR_COORD_W]  = SRC_X;
        hdr[HDR_SRCY_LSB +: HDR_COORD_W]  = SRC_Y;
        hdr[HDR_LEN_LSB  +: HDR_LEN_W]    = len_q;
        hdr[n-1 -: FLIT_TYPE_W]           = hdr_type;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_fire && cmd_legal) state_d = ST_HEAD;
            ST_HEAD: if (out_fire) state_d = (len_q == 8'd0) ? ST_IDLE : ST_BODY;
            ST_BODY: if (out_fire && (remaining_q == 8'd1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready         = 1'b0;
        pay_ready         = 1'b0;
        proc_output_valid = 1'b0;
        proc_output_data  = '0;
        case (state_q)
            // Gated by rst so no command can slip in during the reset cycle itself.
            ST_IDLE: cmd_ready = !rst;
            ST_HEAD: begin
                proc_output_valid = 1'b1;
                proc_output_data  = hdr;
            end
            ST_BODY: begin
                proc_output_valid = pay_valid;
                pay_ready         = proc_output_ready;
                proc_output_data  = {body_type, pay_data};
            end
            default: ;
        endcase
    end

    // Command fields, remaining count, status pulses and packet counter
    always_ff @(posedge clk) begin
        if (rst) begin
            dstx_q      <= '0;
            dsty_q      <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            pkt_sent    <= 1'b0;
            cmd_err     <= 1'b0;
            pkt_count   <= '0;
        end else begin
            pkt_sent <= out_fire && last_flit;
            cmd_err  <= cmd_fire && !cmd_legal;
            if (cmd_fire && cmd_legal) begin
                dstx_q      <= cmd_dstx;
                dsty_q      <= cmd_dsty;
                len_q       <= cmd_len;
                remaining_q <= cmd_len;
            end else if ((state_q == ST_BODY) && out_fire) begin
                remaining_q <= remaining_q - 8'd1;
            end
            if (out_fire && last_flit) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_proc_injector.sv
// Randomized bench for proc_injector with a packet-level reference model.
// Latency: n/a (testbench).
// Backpressure: random ready and payload gaps drive the DUT.
module tb_proc_injector;

    localparam int N    = 32;
    localparam int SRCX = 0;
    localparam int SRCY = 0;
    localparam int MAXX = 1;
    localparam int MAXY = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [3:0]    cmd_dstx, cmd_dsty;
    logic [7:0]    cmd_len;
    logic          pay_valid, pay_ready;
    logic [N-3:0]  pay_data;
    logic          out_valid, out_ready;
    logic [N-1:0]  out_data;
    logic          pkt_sent, cmd_err;
    logic [15:0]   pkt_count;

    always #5 clk = ~clk;

    proc_injector #(.n(N), .srcx(SRCX), .srcy(SRCY), .maxx(MAXX), .maxy(MAXY)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dstx(cmd_dstx), .cmd_dsty(cmd_dsty), .cmd_len(cmd_len),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
        .proc_output_valid(out_valid), .proc_output_ready(out_ready),
        .proc_output_data(out_data),
        .pkt_sent(pkt_sent), .cmd_err(cmd_err), .pkt_count(pkt_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [N-1:0] exp_q[$];        // flits still owed by the DUT for the current packet
    logic [N-3:0] pay_q[$];        // payload words the bench source still has to offer
    logic [N-3:0] forced_pay[$];   // directed payload values, used before random ones
    int           xfer_cyc[$];
    logic [N-1:0] xfer_dat[$];
    int           acc_cyc[$];
    int           cyc = 0;
    int           model_count = 0;
    bit           sent_due = 0, err_due = 0, after_rst = 0;
    bit           prev_stall = 0;
    logic [N-1:0] prev_data = '0;
    bit           pay_fired = 0, pay_flush = 0;

    // Stimulus knobs
    bit force_ready = 1, ready_rand = 0, pay_gaps = 0;

    function automatic bit illegal(input int dx, input int dy);
        return (dx > MAXX) || (dy > MAXY) || (dx == SRCX && dy == SRCY);
    endfunction

    function automatic logic [N-1:0] hdr_model(input int dx, input int dy, input int len);
        int typ;
        typ = (len == 0) ? 3 : 2;
        return (32'(typ) << 30) | (32'(len) << 16) | (32'(SRCY) << 12) |
               (32'(SRCX) << 8) | (32'(dy) << 4) | 32'(dx);
    endfunction

    // Monitor and reference model, sampled on the falling edge.
    always @(negedge clk) begin
        bit idle, in_hdr, in_body, exp_valid;
        cyc++;
        if (rst) begin
            check("rst_cmd_ready", cmd_ready, 0);
            exp_q.delete();
            pay_q.delete();
            pay_fired = 0;
            pay_flush = 1;
            sent_due = 0;
            err_due = 0;
            model_count = 0;
            prev_stall = 0;
            after_rst = 1;
        end else begin
            if (after_rst) begin
                check("rst_valid", out_valid, 0);
                check("rst_data", out_data, 0);
                check("rst_pkt_count", pkt_count, 0);
                after_rst = 0;
            end
            check("pkt_sent", pkt_sent, sent_due);
            if (sent_due) model_count = (model_count + 1) % 65536;
            sent_due = 0;
            check("cmd_err", cmd_err, err_due);
            err_due = 0;
            check("pkt_count", pkt_count, model_count);

            idle    = (exp_q.size() == 0);
            in_hdr  = !idle && exp_q[0][N-1];
            in_body = !idle && !in_hdr;
            exp_valid = idle ? 1'b0 : (in_hdr ? 1'b1 : pay_valid);
            check("cmd_ready", cmd_ready, idle);
            check("pay_ready", pay_ready, in_body && out_ready);
            check("valid", out_valid, exp_valid);
            if (prev_stall) check("stall_hold", out_data, prev_data);
            if (out_valid && exp_valid) check("flit", out_data, exp_q[0]);

            if (out_valid && out_ready && !idle) begin
                xfer_cyc.push_back(cyc);
                xfer_dat.push_back(out_data);
                if (exp_q[0][N-2]) sent_due = 1;   // TAIL or HEADTAIL ends the packet
                if (in_body) pay_fired = 1;
                void'(exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;

            if (cmd_valid && cmd_ready) begin
                acc_cyc.push_back(cyc);
                if (illegal(int'(cmd_dstx), int'(cmd_dsty))) begin
                    err_due = 1;
                end else begin
                    exp_q.push_back(hdr_model(int'(cmd_dstx), int'(cmd_dsty), int'(cmd_len)));
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        logic [N-3:0] w;
                        w = (forced_pay.size() > 0) ? forced_pay.pop_front() : (N-2)'($urandom);
                        pay_q.push_back(w);
                        exp_q.push_back(((i == int'(cmd_len) - 1) ? (32'd1 << 30) : 32'd0) | 32'(w));
                    end
                end
            end
        end
    end

    // Ready and payload source, driven late in the cycle.
    always @(posedge clk) begin
        #2;
        out_ready = ready_rand ? ($urandom_range(0, 9) < 6) : force_ready;
        if (pay_flush) begin
            pay_valid = 0;
            pay_flush = 0;
            pay_fired = 0;
        end else begin
            if (pay_fired) begin
                void'(pay_q.pop_front());
                pay_valid = 0;
                pay_fired = 0;
            end
            if (!pay_valid && pay_q.size() > 0 && (!pay_gaps || $urandom_range(0, 2) != 0)) begin
                pay_valid = 1;
                pay_data  = pay_q[0];
            end
        end
    end

    task automatic send_cmd(input int dx, input int dy, input int len);
        bit done;
        done = 0;
        @(posedge clk); #1;
        cmd_valid = 1;
        cmd_dstx  = 4'(dx);
        cmd_dsty  = 4'(dy);
        cmd_len   = 8'(len);
        for (int k = 0; k < 4000 && !done; k++) begin
            @(negedge clk);
            if (cmd_ready) done = 1;
        end
        if (!done) check("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int k = 0; k < 6000 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !sent_due && !err_due) done = 1;
        end
        if (!done) check("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_logs();
        xfer_cyc.delete();
        xfer_dat.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int legal_cmds;
        logic [15:0] cnt_before;
        rst = 1; cmd_valid = 0; cmd_dstx = 0; cmd_dsty = 0; cmd_len = 0;
        pay_valid = 0; pay_data = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_pkt_count", pkt_count, 0);

        // Basic packet: back-to-back flits after the header.
        clear_logs();
        forced_pay.push_back(30'h1234);
        forced_pay.push_back(30'h5678);
        send_cmd(1, 1, 2);
        wait_idle();
        check("t1_nflits", xfer_dat.size(), 3);
        if (xfer_dat.size() == 3) begin
            check("t1_hdr", xfer_dat[0], 32'h8002_0011);
            check("t1_body", xfer_dat[1], 32'h0000_1234);
            check("t1_tail", xfer_dat[2], 32'h4000_5678);
            check("t1_hdr_lat", xfer_cyc[0] - acc_cyc[0], 1);
            check("t1_gap1", xfer_cyc[1] - xfer_cyc[0], 1);
            check("t1_gap2", xfer_cyc[2] - xfer_cyc[1], 1);
        end
        check("t1_count", pkt_count, 1);

        // Zero-length packet.
        clear_logs();
        send_cmd(1, 0, 0);
        wait_idle();
        check("t2_nflits", xfer_dat.size(), 1);
        if (xfer_dat.size() == 1) check("t2_flit", xfer_dat[0], 32'hC000_0001);
        check("t2_count", pkt_count, 2);

        // Header held for three stalled cycles.
        clear_logs();
        force_ready = 0;
        send_cmd(1, 1, 2);
        repeat (3) @(posedge clk);
        #1 force_ready = 1;
        wait_idle();
        check("t3_nflits", xfer_dat.size(), 3);
        if (xfer_dat.size() == 3) begin
            check("t3_hdr", xfer_dat[0], 32'h8002_0011);
            check("t3_hdr_lat", xfer_cyc[0] - acc_cyc[0], 4);
        end

        // Illegal destinations.
        clear_logs();
        cnt_before = pkt_count;
        send_cmd(2, 0, 3);
        send_cmd(0, 0, 1);
        wait_idle();
        check("t5_no_flits", xfer_dat.size(), 0);
        check("t5_count", pkt_count, cnt_before);

        // Reset in the middle of a len=5 body.
        clear_logs();
        send_cmd(0, 1, 5);
        for (int k = 0; k < 200 && xfer_dat.size() < 3; k++) @(negedge clk);
        check("t6_progress", xfer_dat.size(), 3);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("t6_valid", out_valid, 0);
        check("t6_count", pkt_count, 0);
        check("t6_idle", cmd_ready, 1);
        clear_logs();
        send_cmd(1, 0, 1);
        wait_idle();
        check("t6_new_pkt", xfer_dat.size(), 2);
        check("t6_new_count", pkt_count, 1);

        // Random traffic with body backpressure and payload gaps.
        ready_rand = 1;
        pay_gaps = 1;
        legal_cmds = 0;
        for (int i = 0; i < 40; i++) begin
            int dx, dy, len;
            dx  = $urandom_range(0, 2);
            dy  = $urandom_range(0, 2);
            len = (i == 7) ? 255 : $urandom_range(0, 6);
            if (!illegal(dx, dy)) legal_cmds++;
            send_cmd(dx, dy, len);
        end
        wait_idle();
        check("rand_count", pkt_count, 16'(1 + legal_cmds));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
